// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one single-port synchronous memory between
// instruction fetch and data access, data first with bounded fetch starvation.
module mem_port_arbiter #(
  parameter int ADDR_WIDTH = 14,
  parameter int MAX_STREAK = 4
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  if_req_i,
  input  logic [ADDR_WIDTH-1:0] if_addr_i,
  output logic                  if_gnt_o,
  output logic                  if_rvalid_o,
  output logic [31:0]           if_rdata_o,
  input  logic                  d_req_i,
  input  logic [3:0]            d_we_i,
  input  logic [ADDR_WIDTH-1:0] d_addr_i,
  input  logic [31:0]           d_wdata_i,
  output logic                  d_gnt_o,
  output logic                  d_rvalid_o,
  output logic [31:0]           d_rdata_o,
  output logic [ADDR_WIDTH-1:0] mem_addr_o,
  output logic [3:0]            mem_wr_o,
  output logic [31:0]           mem_wdata_o,
  input  logic [31:0]           mem_rdata_i
);

  localparam int SW = $clog2(MAX_STREAK + 1);
  localparam logic [SW-1:0] SMAX = SW'(MAX_STREAK);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    IF_RD = 2'd1,
    D_RD  = 2'd2,
    D_WR  = 2'd3
  } state_t;

  state_t        state_q, state_d;
  logic [SW-1:0] streak_q, streak_d;
  logic          data_win;
  logic          if_gnt, d_gnt;

  // Grant: data wins unless fetch has waited out a full streak.
  always_comb begin
    data_win = d_req_i && !(if_req_i && (streak_q == SMAX));
    d_gnt    = !reset && data_win;
    if_gnt   = !reset && if_req_i && !data_win;
  end

  assign if_gnt_o = if_gnt;
  assign d_gnt_o  = d_gnt;

  // Memory port steering; the idle default points at the fetch address.
  always_comb begin
    mem_addr_o  = if_addr_i;
    mem_wr_o    = 4'b0000;
    mem_wdata_o = d_wdata_i;
    if (reset) begin
      mem_addr_o = '0;
    end else if (d_gnt) begin
      mem_addr_o = d_addr_i;
      mem_wr_o   = d_we_i;
    end
  end

  // Streak of data grants taken while fetch was kept waiting.
  always_comb begin
    streak_d = streak_q;
    if (!if_req_i || if_gnt) begin
      streak_d = '0;
    end else if (d_gnt && (streak_q != SMAX)) begin
      streak_d = streak_q + 1'b1;
    end
  end

  // Owner of the access issued this cycle, used to route next cycle's data.
  always_comb begin
    state_d = IDLE;
    unique case (1'b1)
      if_gnt:                state_d = IF_RD;
      d_gnt && ~|d_we_i:     state_d = D_RD;
      d_gnt && |d_we_i:      state_d = D_WR;
      default:               state_d = IDLE;
    endcase
  end

  // State and streak registers.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      streak_q <= '0;
    end else begin
      state_q  <= state_d;
      streak_q <= streak_d;
    end
  end

  // Read data return, zeroed on the interface that does not own it.
  always_comb begin
    if_rvalid_o = (state_q == IF_RD);
    d_rvalid_o  = (state_q == D_RD);
    if_rdata_o  = if_rvalid_o ? mem_rdata_i : 32'h0;
    d_rdata_o   = d_rvalid_o ? mem_rdata_i : 32'h0;
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed vectors into a scoreboard; a negedge
// monitor checks grants, memory port and returned read data.
module tb_mem_port_arbiter;

  localparam int AW = 14;

  logic          clk = 1'b0;
  logic          reset;
  logic          if_req;
  logic [AW-1:0] if_addr;
  logic          if_gnt, if_rvalid;
  logic [31:0]   if_rdata;
  logic          d_req;
  logic [3:0]    d_we;
  logic [AW-1:0] d_addr;
  logic [31:0]   d_wdata;
  logic          d_gnt, d_rvalid;
  logic [31:0]   d_rdata;
  logic [AW-1:0] mem_addr;
  logic [3:0]    mem_wr;
  logic [31:0]   mem_wdata;
  logic [31:0]   mem_rdata;

  int total = 0;
  int bad   = 0;

  typedef struct packed {
    logic          ig;
    logic          dg;
    logic [3:0]    wr;
    logic [AW-1:0] addr;
  } gexp_t;

  gexp_t       gq[$];
  logic [31:0] iq[$];
  logic [31:0] dq[$];

  mem_port_arbiter #(.ADDR_WIDTH(AW), .MAX_STREAK(4)) dut (
    .clock      (clk),
    .reset      (reset),
    .if_req_i   (if_req),
    .if_addr_i  (if_addr),
    .if_gnt_o   (if_gnt),
    .if_rvalid_o(if_rvalid),
    .if_rdata_o (if_rdata),
    .d_req_i    (d_req),
    .d_we_i     (d_we),
    .d_addr_i   (d_addr),
    .d_wdata_i  (d_wdata),
    .d_gnt_o    (d_gnt),
    .d_rvalid_o (d_rvalid),
    .d_rdata_o  (d_rdata),
    .mem_addr_o (mem_addr),
    .mem_wr_o   (mem_wr),
    .mem_wdata_o(mem_wdata),
    .mem_rdata_i(mem_rdata)
  );

  always #5 clk = ~clk;

  // Single-port synchronous RAM with byte enables, preloaded on first edge.
  logic [31:0] mem [0:(1<<AW)-1];
  logic        loaded = 1'b0;
  always @(posedge clk) begin
    if (!loaded) begin
      mem[14'h010] <= 32'h11223344;
      mem[14'h020] <= 32'h20202020;
      mem[14'h030] <= 32'h30303030;
      mem[14'h040] <= 32'h40404040;
      mem[14'h0A6] <= 32'hCAFE00A6;
      mem[14'h0A7] <= 32'hCAFE00A7;
      mem[14'h0A8] <= 32'hCAFE00A8;
      loaded <= 1'b1;
    end else begin
      for (int b = 0; b < 4; b++)
        if (mem_wr[b]) mem[mem_addr][8*b +: 8] <= mem_wdata[8*b +: 8];
    end
    mem_rdata <= mem[mem_addr];
  end

  // Monitor: grants every cycle, read data whenever an rvalid shows up.
  always @(negedge clk) begin
    gexp_t g;
    logic [31:0] e;
    if (gq.size() > 0) begin
      g = gq.pop_front();
      total++;
      if (if_gnt !== g.ig || d_gnt !== g.dg ||
          mem_wr !== g.wr || mem_addr !== g.addr) begin
        bad++;
        $display("FAIL grant t=%0t: got ig=%b dg=%b wr=%h a=%h want ig=%b dg=%b wr=%h a=%h",
                 $time, if_gnt, d_gnt, mem_wr, mem_addr,
                 g.ig, g.dg, g.wr, g.addr);
      end
    end
    total++;
    if (if_rvalid === 1'b1) begin
      if (iq.size() == 0) begin
        bad++;
        $display("FAIL if_rvalid t=%0t: got unexpected rvalid data=%h", $time, if_rdata);
      end else begin
        e = iq.pop_front();
        if (if_rdata !== e) begin
          bad++;
          $display("FAIL if_rdata t=%0t: got %h want %h", $time, if_rdata, e);
        end
      end
    end else if (if_rdata !== 32'h0 || if_rvalid !== 1'b0) begin
      bad++;
      $display("FAIL if_idle t=%0t: got rvalid=%b rdata=%h want 0", $time, if_rvalid, if_rdata);
    end
    total++;
    if (d_rvalid === 1'b1) begin
      if (dq.size() == 0) begin
        bad++;
        $display("FAIL d_rvalid t=%0t: got unexpected rvalid data=%h", $time, d_rdata);
      end else begin
        e = dq.pop_front();
        if (d_rdata !== e) begin
          bad++;
          $display("FAIL d_rdata t=%0t: got %h want %h", $time, d_rdata, e);
        end
      end
    end else if (d_rdata !== 32'h0 || d_rvalid !== 1'b0) begin
      bad++;
      $display("FAIL d_idle t=%0t: got rvalid=%b rdata=%h want 0", $time, d_rvalid, d_rdata);
    end
  end

  // One cycle of stimulus plus its expected grant and read responses.
  task automatic cyc(input logic r, input logic ir, input logic [AW-1:0] ia,
                     input logic dr, input logic [3:0] we,
                     input logic [AW-1:0] da, input logic [31:0] wd,
                     input logic eig, input logic edg,
                     input logic [31:0] eid, input logic [31:0] edd,
                     input logic kill);
    gexp_t g;
    reset   = r;
    if_req  = ir;
    if_addr = ia;
    d_req   = dr;
    d_we    = we;
    d_addr  = da;
    d_wdata = wd;
    g.ig   = eig;
    g.dg   = edg;
    g.wr   = edg ? we : 4'b0000;
    g.addr = r ? '0 : (edg ? da : ia);
    gq.push_back(g);
    if (eig) iq.push_back(eid);
    if (edg && we == 4'b0000 && !kill) dq.push_back(edd);
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    cyc(0, 0, 14'h0, 0, 4'h0, 14'h0, 32'h0, 0, 0, 32'h0, 32'h0, 0);
  endtask

  initial begin
    reset   = 1'b1;
    if_req  = 1'b1;
    if_addr = 14'h0A6;
    d_req   = 1'b1;
    d_we    = 4'h0;
    d_addr  = 14'h020;
    d_wdata = 32'h0;
    @(posedge clk);
    #1;
    // reset held with both requests
    cyc(1, 1, 14'h0A6, 1, 4'h0, 14'h020, 32'h0, 0, 0, 32'h0, 32'h0, 0);
    cyc(1, 1, 14'h0A6, 1, 4'h0, 14'h020, 32'h0, 0, 0, 32'h0, 32'h0, 0);
    // release: data wins first
    cyc(0, 1, 14'h0A6, 1, 4'h0, 14'h020, 32'h0, 0, 1, 32'h0, 32'h20202020, 0);
    // fetch burst
    cyc(0, 1, 14'h0A6, 0, 4'h0, 14'h000, 32'h0, 1, 0, 32'hCAFE00A6, 32'h0, 0);
    cyc(0, 1, 14'h0A7, 0, 4'h0, 14'h000, 32'h0, 1, 0, 32'hCAFE00A7, 32'h0, 0);
    cyc(0, 1, 14'h0A8, 0, 4'h0, 14'h000, 32'h0, 1, 0, 32'hCAFE00A8, 32'h0, 0);
    idle();
    // partial write then read-back
    cyc(0, 0, 14'h000, 1, 4'b0011, 14'h010, 32'hDEADBEEF, 0, 1, 32'h0, 32'h0, 0);
    cyc(0, 0, 14'h000, 1, 4'b0000, 14'h010, 32'h0, 0, 1, 32'h0, 32'h1122BEEF, 0);
    idle();
    // starvation bound
    for (int i = 0; i < 10; i++) begin
      logic f;
      f = (i % 5 == 4);
      cyc(0, 1, 14'h030, 1, 4'h0, 14'h040, 32'h0, f, !f,
          32'h30303030, 32'h40404040, 0);
    end
    idle();
    // alternating requesters
    cyc(0, 1, 14'h0A6, 0, 4'h0, 14'h000, 32'h0, 1, 0, 32'hCAFE00A6, 32'h0, 0);
    cyc(0, 0, 14'h000, 1, 4'h0, 14'h020, 32'h0, 0, 1, 32'h0, 32'h20202020, 0);
    cyc(0, 1, 14'h0A7, 0, 4'h0, 14'h000, 32'h0, 1, 0, 32'hCAFE00A7, 32'h0, 0);
    cyc(0, 0, 14'h000, 1, 4'h0, 14'h010, 32'h0, 0, 1, 32'h0, 32'h1122BEEF, 0);
    cyc(0, 1, 14'h0A8, 0, 4'h0, 14'h000, 32'h0, 1, 0, 32'hCAFE00A8, 32'h0, 0);
    cyc(0, 0, 14'h000, 1, 4'h0, 14'h040, 32'h0, 0, 1, 32'h0, 32'h40404040, 0);
    idle();
    // build a partial streak, then reset right after a data read grant
    cyc(0, 1, 14'h030, 1, 4'h0, 14'h040, 32'h0, 0, 1, 32'h0, 32'h40404040, 0);
    cyc(0, 1, 14'h030, 1, 4'h0, 14'h040, 32'h0, 0, 1, 32'h0, 32'h40404040, 1);
    cyc(1, 1, 14'h030, 1, 4'h0, 14'h040, 32'h0, 0, 0, 32'h0, 32'h0, 0);
    // streak restarts from zero after reset
    for (int i = 0; i < 5; i++) begin
      logic f;
      f = (i == 4);
      cyc(0, 1, 14'h030, 1, 4'h0, 14'h040, 32'h0, f, !f,
          32'h30303030, 32'h40404040, 0);
    end
    idle();
    idle();
    @(negedge clk);
    #1;
    total++;
    if (gq.size() != 0 || iq.size() != 0 || dq.size() != 0) begin
      bad++;
      $display("FAIL drain: got pending g=%0d i=%0d d=%0d want 0 0 0",
               gq.size(), iq.size(), dq.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
